// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla_plus fetch stage: opcodes, instruction field layout, FSM states.
package jericalla_pkg;

  localparam int unsigned INSTR_WIDTH = 17;
  localparam int unsigned REG_WIDTH   = 5;

  localparam int unsigned OPC_MSB  = 16;
  localparam int unsigned OPC_LSB  = 15;
  localparam int unsigned DST_MSB  = 14;
  localparam int unsigned DST_LSB  = 10;
  localparam int unsigned SRCA_MSB = 9;
  localparam int unsigned SRCA_LSB = 5;
  localparam int unsigned SRCB_MSB = 4;
  localparam int unsigned SRCB_LSB = 0;

  localparam logic [1:0] OPC_SUMA  = 2'b00;
  localparam logic [1:0] OPC_RESTA = 2'b01;
  localparam logic [1:0] OPC_TERN  = 2'b10;
  localparam logic [1:0] OPC_HALT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

endpackage

// File: rtl/fetch_hazard_check.sv
// Read-after-write detector: flags a candidate whose sources match a destination still in flight.
module fetch_hazard_check
  import jericalla_pkg::*;
(
  input  logic [REG_WIDTH-1:0] i_src_a,
  input  logic [REG_WIDTH-1:0] i_src_b,
  input  logic [REG_WIDTH-1:0] i_hist0_dst,
  input  logic                 i_hist0_vld,
  input  logic [REG_WIDTH-1:0] i_hist1_dst,
  input  logic                 i_hist1_vld,
  output logic                 o_hazard_c
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_hist0_vld && ((i_src_a == i_hist0_dst) || (i_src_b == i_hist0_dst));
  assign w_hit1 = i_hist1_vld && ((i_src_a == i_hist1_dst) || (i_src_b == i_hist1_dst));
  assign o_hazard_c = w_hit0 || w_hit1;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, constant instruction ROM, IDLE/RUN/HALT control and bubble insertion on RAW hazards.
module instruction_fetch
  import jericalla_pkg::*;
#(
  parameter int unsigned                   DEPTH      = 32,
  parameter int unsigned                   ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DEPTH*INSTR_WIDTH-1:0]  ROM_INIT   = '0
)(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted
);

  state_e                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  logic                   r_halted;
  logic [REG_WIDTH-1:0]   r_hist0_dst;
  logic                   r_hist0_vld;
  logic [REG_WIDTH-1:0]   r_hist1_dst;
  logic                   r_hist1_vld;

  logic [INSTR_WIDTH-1:0] w_rom [DEPTH];
  logic [INSTR_WIDTH-1:0] w_cand;
  logic [REG_WIDTH-1:0]   w_dst;
  logic [REG_WIDTH-1:0]   w_src_a;
  logic [REG_WIDTH-1:0]   w_src_b;
  logic                   w_is_halt;
  logic                   w_hazard;
  logic [ADDR_WIDTH-1:0]  w_pc_next;

  // ROM image is an elaboration-time constant, so the array reduces to a constant mux on r_pc
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_rom[i] = ROM_INIT[i*INSTR_WIDTH +: INSTR_WIDTH];
    end
  end

  assign w_cand    = w_rom[r_pc];
  assign w_dst     = w_cand[DST_MSB:DST_LSB];
  assign w_src_a   = w_cand[SRCA_MSB:SRCA_LSB];
  assign w_src_b   = w_cand[SRCB_MSB:SRCB_LSB];
  assign w_is_halt = (w_cand[OPC_MSB:OPC_LSB] == OPC_HALT);
  assign w_pc_next = (r_pc == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_pc + ADDR_WIDTH'(1);

  fetch_hazard_check u_hazard (
    .i_src_a     (w_src_a),
    .i_src_b     (w_src_b),
    .i_hist0_dst (r_hist0_dst),
    .i_hist0_vld (r_hist0_vld),
    .i_hist1_dst (r_hist1_dst),
    .i_hist1_vld (r_hist1_vld),
    .o_hazard_c  (w_hazard)
  );

  // Control FSM and output register; priority in RUN is stall, halt, hazard, issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
      r_hist0_dst <= '0;
      r_hist0_vld <= 1'b0;
      r_hist1_dst <= '0;
      r_hist1_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            if (w_is_halt) begin
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else if (w_hazard) begin
              r_valid     <= 1'b0;
              r_instr     <= '0;
              r_hist1_dst <= r_hist0_dst;
              r_hist1_vld <= r_hist0_vld;
              r_hist0_vld <= 1'b0;
            end else begin
              r_instr     <= w_cand;
              r_valid     <= 1'b1;
              r_pc        <= w_pc_next;
              r_hist1_dst <= r_hist0_dst;
              r_hist1_vld <= r_hist0_vld;
              r_hist0_dst <= w_dst;
              r_hist0_vld <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one DUT instance per ROM image, shared clock and reset.
module tb_instruction_fetch;

  localparam logic [16:0] A  = 17'b00_00100_00000_00001;
  localparam logic [16:0] B  = 17'b01_00101_00100_00010;
  localparam logic [16:0] H  = 17'b11_00000_00000_00000;
  localparam logic [16:0] I0 = 17'b00_00001_00010_00011;
  localparam logic [16:0] I1 = 17'b01_00100_00101_00110;
  localparam logic [16:0] I2 = 17'b10_00111_01000_01001;
  localparam logic [16:0] I3 = 17'b00_01010_01011_01100;

  localparam logic [32*17-1:0] ROM_T1  = {{30{17'b0}}, H, A};
  localparam logic [32*17-1:0] ROM_IND = {{27{17'b0}}, H, I3, I2, I1, I0};
  localparam logic [32*17-1:0] ROM_RAW = {{29{17'b0}}, H, B, A};
  localparam logic [4*17-1:0]  ROM_WRP = {I3, I2, I1, I0};

  logic        clock;
  logic        reset_n;
  logic [3:0]  start;
  logic [3:0]  stall;
  logic [16:0] instr [4];
  logic [3:0]  vld;
  logic [3:0]  hlt;
  logic [4:0]  pc0, pc1, pc2;
  logic [1:0]  pc3;

  int n_cmp  = 0;
  int n_fail = 0;

  instruction_fetch #(.ROM_INIT(ROM_T1)) u_t1 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .stall(stall[0]),
    .instruction(instr[0]), .instr_valid(vld[0]), .pc(pc0), .halted(hlt[0]));

  instruction_fetch #(.ROM_INIT(ROM_IND)) u_ind (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .stall(stall[1]),
    .instruction(instr[1]), .instr_valid(vld[1]), .pc(pc1), .halted(hlt[1]));

  instruction_fetch #(.ROM_INIT(ROM_RAW)) u_raw (
    .clock(clock), .reset_n(reset_n), .start(start[2]), .stall(stall[2]),
    .instruction(instr[2]), .instr_valid(vld[2]), .pc(pc2), .halted(hlt[2]));

  instruction_fetch #(.DEPTH(4), .ROM_INIT(ROM_WRP)) u_wrap (
    .clock(clock), .reset_n(reset_n), .start(start[3]), .stall(stall[3]),
    .instruction(instr[3]), .instr_valid(vld[3]), .pc(pc3), .halted(hlt[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = '0;
    stall   = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = '0; stall = '0;
    tick();
    n_cmp++; if (instr[0] !== 17'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", instr[0]); end
    n_cmp++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", vld[0]); end
    n_cmp++; if (hlt[0] !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", hlt[0]); end
    n_cmp++; if (pc0 !== 5'd0) begin n_fail++; $display("FAIL rst_pc got %0d want 0", pc0); end
    reset_n = 1'b1;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n_cmp++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL t1_latency_valid got %b want 0", vld[0]); end
    tick();
    n_cmp++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL t1_first_valid got %b want 1", vld[0]); end
    n_cmp++; if (instr[0] !== A) begin n_fail++; $display("FAIL t1_first_instr got %b want %b", instr[0], A); end
    n_cmp++; if (pc0 !== 5'd1) begin n_fail++; $display("FAIL t1_first_pc got %0d want 1", pc0); end
    tick();
    n_cmp++; if (hlt[0] !== 1'b1) begin n_fail++; $display("FAIL t1_halted got %b want 1", hlt[0]); end
    n_cmp++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL t1_halt_valid got %b want 0", vld[0]); end
    n_cmp++; if (pc0 !== 5'd1) begin n_fail++; $display("FAIL t1_halt_pc got %0d want 1", pc0); end
    n_cmp++; if (instr[0] !== A) begin n_fail++; $display("FAIL t1_halt_instr_hold got %b want %b", instr[0], A); end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    n_cmp++; if (hlt[0] !== 1'b1 || vld[0] !== 1'b0 || pc0 !== 5'd1) begin
      n_fail++; $display("FAIL t1_start_in_halt got h=%b v=%b pc=%0d want h=1 v=0 pc=1", hlt[0], vld[0], pc0);
    end
  endtask

  task automatic test_independent();
    logic [16:0] exp_i [4];
    exp_i = '{I0, I1, I2, I3};
    do_reset();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (vld[1] !== 1'b1 || instr[1] !== exp_i[k] || pc1 !== 5'(k + 1)) begin
        n_fail++; $display("FAIL ind_issue%0d got v=%b i=%b pc=%0d want v=1 i=%b pc=%0d", k, vld[1], instr[1], pc1, exp_i[k], k + 1);
      end
    end
    tick();
    n_cmp++; if (hlt[1] !== 1'b1 || vld[1] !== 1'b0 || pc1 !== 5'd4) begin
      n_fail++; $display("FAIL ind_halt got h=%b v=%b pc=%0d want h=1 v=0 pc=4", hlt[1], vld[1], pc1);
    end
  endtask

  task automatic test_raw_hazard();
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (vld[2] !== pat[3 - k]) begin
        n_fail++; $display("FAIL raw_valid_cycle%0d got %b want %b", k + 1, vld[2], pat[3 - k]);
      end
      if (k == 1) begin
        n_cmp++; if (instr[2] !== 17'h0 || pc2 !== 5'd1) begin
          n_fail++; $display("FAIL raw_bubble got i=%h pc=%0d want i=0 pc=1", instr[2], pc2);
        end
      end
    end
    n_cmp++; if (instr[2] !== B || pc2 !== 5'd2) begin
      n_fail++; $display("FAIL raw_second_issue got i=%b pc=%0d want i=%b pc=2", instr[2], pc2, B);
    end
    tick();
    n_cmp++; if (hlt[2] !== 1'b1) begin n_fail++; $display("FAIL raw_halt got %b want 1", hlt[2]); end
  endtask

  task automatic test_stall();
    do_reset();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    tick();
    tick();
    n_cmp++; if (instr[1] !== I1 || pc1 !== 5'd2) begin
      n_fail++; $display("FAIL stall_pre got i=%b pc=%0d want i=%b pc=2", instr[1], pc1, I1);
    end
    stall[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (instr[1] !== I1 || vld[1] !== 1'b1 || pc1 !== 5'd2) begin
        n_fail++; $display("FAIL stall_hold%0d got i=%b v=%b pc=%0d want i=%b v=1 pc=2", k, instr[1], vld[1], pc1, I1);
      end
    end
    stall[1] = 1'b0;
    tick();
    n_cmp++; if (instr[1] !== I2 || vld[1] !== 1'b1 || pc1 !== 5'd3) begin
      n_fail++; $display("FAIL stall_after1 got i=%b v=%b pc=%0d want i=%b v=1 pc=3", instr[1], vld[1], pc1, I2);
    end
    tick();
    n_cmp++; if (instr[1] !== I3 || vld[1] !== 1'b1 || pc1 !== 5'd4) begin
      n_fail++; $display("FAIL stall_after2 got i=%b v=%b pc=%0d want i=%b v=1 pc=4", instr[1], vld[1], pc1, I3);
    end
    tick();
    n_cmp++; if (hlt[1] !== 1'b1 || vld[1] !== 1'b0) begin
      n_fail++; $display("FAIL stall_then_halt got h=%b v=%b want h=1 v=0", hlt[1], vld[1]);
    end
  endtask

  task automatic test_wrap_reset();
    logic [16:0] exp_i [4];
    exp_i = '{I0, I1, I2, I3};
    do_reset();
    n_cmp++; if (pc3 !== 2'd0) begin n_fail++; $display("FAIL wrap_pc_init got %0d want 0", pc3); end
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (pc3 !== 2'(k + 1) || instr[3] !== exp_i[k % 4] || vld[3] !== 1'b1) begin
        n_fail++; $display("FAIL wrap_step%0d got pc=%0d i=%b v=%b want pc=%0d i=%b v=1", k, pc3, instr[3], vld[3], (k + 1) % 4, exp_i[k % 4]);
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (vld[3] !== 1'b0 || pc3 !== 2'd0 || instr[3] !== 17'h0 || hlt[3] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_async_reset got v=%b pc=%0d i=%h h=%b want all 0", vld[3], pc3, instr[3], hlt[3]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (vld[3] !== 1'b0 || pc3 !== 2'd0) begin
      n_fail++; $display("FAIL wrap_idle_after_reset got v=%b pc=%0d want v=0 pc=0", vld[3], pc3);
    end
  endtask

  task automatic test_stall_priority();
    do_reset();
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    tick();
    stall[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (vld[2] !== 1'b1 || instr[2] !== A || pc2 !== 5'd1) begin
        n_fail++; $display("FAIL sp_hazard_hold%0d got v=%b i=%b pc=%0d want v=1 i=%b pc=1", k, vld[2], instr[2], pc2, A);
      end
    end
    stall[2] = 1'b0;
    tick();
    n_cmp++; if (vld[2] !== 1'b0 || pc2 !== 5'd1) begin
      n_fail++; $display("FAIL sp_bubble1 got v=%b pc=%0d want v=0 pc=1", vld[2], pc2);
    end
    tick();
    n_cmp++; if (vld[2] !== 1'b0 || pc2 !== 5'd1) begin
      n_fail++; $display("FAIL sp_bubble2 got v=%b pc=%0d want v=0 pc=1", vld[2], pc2);
    end
    tick();
    n_cmp++; if (vld[2] !== 1'b1 || instr[2] !== B || pc2 !== 5'd2) begin
      n_fail++; $display("FAIL sp_issue_b got v=%b i=%b pc=%0d want v=1 i=%b pc=2", vld[2], instr[2], pc2, B);
    end
    stall[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (hlt[2] !== 1'b0 || vld[2] !== 1'b1 || instr[2] !== B || pc2 !== 5'd2) begin
        n_fail++; $display("FAIL sp_halt_hold%0d got h=%b v=%b i=%b pc=%0d want h=0 v=1 i=%b pc=2", k, hlt[2], vld[2], instr[2], pc2, B);
      end
    end
    stall[2] = 1'b0;
    tick();
    n_cmp++; if (hlt[2] !== 1'b1 || vld[2] !== 1'b0 || pc2 !== 5'd2) begin
      n_fail++; $display("FAIL sp_halt_release got h=%b v=%b pc=%0d want h=1 v=0 pc=2", hlt[2], vld[2], pc2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start   = '0;
    stall   = '0;
    @(negedge clock);
    test_reset();
    test_independent();
    test_raw_hazard();
    test_stall();
    test_wrap_reset();
    test_stall_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
